// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - full-subtractor truth equations as reusable functions
// ---------------------------------------------------------------------------
package sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Difference bit of x - y - br.
   function automatic logic diff_bit(input logic x, input logic y, input logic br);
      diff_bit = x ^ y ^ br;
   endfunction

   // Borrow out of x - y - br: borrow when y is set and x is clear, or when
   // x and y are equal and a borrow is already pending.
   function automatic logic borrow_bit(input logic x, input logic y, input logic br);
      borrow_bit = (~x & y) | (~(x ^ y) & br);
   endfunction

endpackage

// File: rtl/full_sub_bit.sv
// ---------------------------------------------------------------------------
// full_sub_bit
// Combinational one-bit full subtractor: {bo, d} = x - y - br.
// Ports:
//   x   in  minuend bit
//   y   in  subtrahend bit
//   br  in  borrow in
//   d   out difference bit
//   bo  out borrow out
// ---------------------------------------------------------------------------
module full_sub_bit
   import sub_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic br,
   output logic d,
   output logic bo
);

   assign d  = diff_bit(x, y, br);
   assign bo = borrow_bit(x, y, br);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, one bit
// per clock through a single full-subtractor cell and a registered borrow.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-high reset
//   start  in  launch request, sampled only in IDLE
//   a, b   in  operands, captured when start is accepted
//   bin    in  borrow-in, captured when start is accepted
//   busy   out high while bits are being processed
//   done   out one-cycle pulse when diff/bout/ovf are fresh
//   diff   out result modulo 2^WIDTH, held until the next completion
//   bout   out final borrow out (unsigned a < b + bin)
//   ovf    out signed two's-complement overflow
// ---------------------------------------------------------------------------
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res_sh;
   logic             r_borrow;
   logic [CNT_W-1:0] r_cnt;
   logic             r_a_msb;
   logic             r_b_msb;

   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_ovf;

   logic             w_d;
   logic             w_bo;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;
   logic [WIDTH-1:0] w_a_shr;
   logic [WIDTH-1:0] w_b_shr;

   full_sub_bit u_cell (
      .x  (r_a_sh[0]),
      .y  (r_b_sh[0]),
      .br (r_borrow),
      .d  (w_d),
      .bo (w_bo)
   );

   // A one-bit operand has nothing above bit 0, so the shift paths
   // degenerate to the new bit (result) or zero (operands).
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_res_next = w_d;
         assign w_a_shr    = '0;
         assign w_b_shr    = '0;
      end else begin : g_wn
         assign w_res_next = {w_d, r_res_sh[WIDTH-1:1]};
         assign w_a_shr    = {1'b0, r_a_sh[WIDTH-1:1]};
         assign w_b_shr    = {1'b0, r_b_sh[WIDTH-1:1]};
      end
   endgenerate

   assign w_last = (r_cnt == LAST_BIT);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, serial shift and result commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res_sh <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sh   <= a;
                  r_b_sh   <= b;
                  r_res_sh <= '0;
                  r_borrow <= bin;
                  r_cnt    <= '0;
                  // Sign bits are kept aside because the operand registers
                  // are consumed by the shift before the overflow decision.
                  r_a_msb  <= a[WIDTH-1];
                  r_b_msb  <= b[WIDTH-1];
               end
            end
            ST_SHIFT: begin
               r_res_sh <= w_res_next;
               r_a_sh   <= w_a_shr;
               r_b_sh   <= w_b_shr;
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  // w_d is the result MSB on the final bit.
                  r_diff <= w_res_next;
                  r_bout <= w_bo;
                  r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (r_state == ST_SHIFT);
   assign done = (r_state == ST_DONE);
   assign diff = r_diff;
   assign bout = r_bout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Directed bench for serial_subtractor: an 8-bit instance for the main
// scenarios and a 1-bit instance for the full-subtractor truth table.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

   logic       clk;
   logic       rst;

   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;
   logic       ovf;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       bin1;
   logic       busy1;
   logic       done1;
   logic [0:0] diff1;
   logic       bout1;
   logic       ovf1;

   int tests_run;
   int tests_failed;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .bin   (bin1),
      .busy  (busy1),
      .done  (done1),
      .diff  (diff1),
      .bout  (bout1),
      .ovf   (ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one 8-bit operation and wait (bounded) for done. k is the number
   // of cycles from the start edge to the cycle where done was seen (0 when
   // it never came); busy_c counts busy cycles before done.
   task automatic launch8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          output int k, output int busy_c);
      bit seen;
      @(negedge clk);
      a = ia; b = ib; bin = ibin; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      k = 0; busy_c = 0; seen = 0;
      for (int i = 1; i <= 30 && !seen; i++) begin
         @(negedge clk);
         if (busy) busy_c++;
         if (done) begin
            seen = 1;
            k = i;
         end
      end
      $display("[TB] op %02h - %02h - %0d -> diff=%02h bout=%0d ovf=%0d after %0d cycles",
               ia, ib, ibin, diff, bout, ovf, k);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start = 1'b0; a = '0; b = '0; bin = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b ovf=%b, need 0 0 00 0 0",
                  busy, done, diff, bout, ovf);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_after_reset: busy=%b done=%b, need 0 0", busy, done);
      end
   endtask

   task automatic test_basic;
      int k, bc;
      launch8(8'h05, 8'h03, 1'b0, k, bc);
      tests_run++;
      if (k !== 9) begin
         tests_failed++;
         $display("FAIL basic_latency: done at cycle %0d, need 9", k);
      end
      tests_run++;
      if (bc !== 8) begin
         tests_failed++;
         $display("FAIL basic_busy_len: busy cycles %0d, need 8", bc);
      end
      tests_run++;
      if (diff !== 8'h02 || bout !== 1'b0 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_result: diff=%h bout=%b ovf=%b, need 02 0 0", diff, bout, ovf);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h02) begin
         tests_failed++;
         $display("FAIL basic_done_pulse: done=%b busy=%b diff=%h, need 0 0 02", done, busy, diff);
      end
   endtask

   task automatic test_borrow;
      int k, bc;
      launch8(8'h03, 8'h05, 1'b0, k, bc);
      tests_run++;
      if (k !== 9 || diff !== 8'hFE || bout !== 1'b1 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL borrow_3m5: k=%0d diff=%h bout=%b ovf=%b, need 9 FE 1 0", k, diff, bout, ovf);
      end
      launch8(8'h00, 8'h00, 1'b1, k, bc);
      tests_run++;
      if (k !== 9 || diff !== 8'hFF || bout !== 1'b1 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL borrow_bin: k=%0d diff=%h bout=%b ovf=%b, need 9 FF 1 0", k, diff, bout, ovf);
      end
   endtask

   task automatic test_overflow;
      int k, bc;
      launch8(8'h80, 8'h01, 1'b0, k, bc);
      tests_run++;
      if (diff !== 8'h7F || bout !== 1'b0 || ovf !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_neg: diff=%h bout=%b ovf=%b, need 7F 0 1", diff, bout, ovf);
      end
      launch8(8'h7F, 8'hFF, 1'b0, k, bc);
      tests_run++;
      if (diff !== 8'h80 || bout !== 1'b1 || ovf !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_pos: diff=%h bout=%b ovf=%b, need 80 1 1", diff, bout, ovf);
      end
   endtask

   // start held high and operands changed mid-flight
   task automatic test_back_to_back;
      int dones;
      int k2;
      bit seen;
      @(negedge clk);
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 a = 8'hAA; b = 8'h55;
      dones = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (done) dones++;
         if (i == 9) begin
            tests_run++;
            if (done !== 1'b1 || diff !== 8'h0F) begin
               tests_failed++;
               $display("FAIL hold_first: done=%b diff=%h at cycle 9, need 1 0F", done, diff);
            end
         end
         if (i == 10) begin
            tests_run++;
            if (busy !== 1'b0 || diff !== 8'h0F) begin
               tests_failed++;
               $display("FAIL hold_idle_gap: busy=%b diff=%h at cycle 10, need 0 0F", busy, diff);
            end
         end
      end
      $display("[TB] op 10 - 01 - 0 (start held) -> diff=%02h dones=%0d", diff, dones);
      tests_run++;
      if (dones !== 1) begin
         tests_failed++;
         $display("FAIL hold_single_done: %0d done pulses, need 1", dones);
      end
      // Second op was accepted at the edge ending the IDLE cycle.
      @(negedge clk);
      start = 1'b0;
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_second_start: busy=%b, need 1", busy);
      end
      seen = 0; k2 = 0;
      for (int i = 1; i <= 30 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            k2 = i;
         end
      end
      $display("[TB] op AA - 55 - 0 -> diff=%02h bout=%0d ovf=%0d", diff, bout, ovf);
      tests_run++;
      if (k2 !== 8 || diff !== 8'h55 || bout !== 1'b0 || ovf !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_second_result: k=%0d diff=%h bout=%b ovf=%b, need 8 55 0 1",
                  k2, diff, bout, ovf);
      end
   endtask

   task automatic test_async_reset;
      int k, bc;
      @(negedge clk);
      a = 8'h20; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      // Mid-cycle, away from any clock edge, during the 4th SHIFT cycle.
      #2 rst = 1'b1;
      #1;
      $display("[TB] async reset mid-op -> busy=%0d done=%0d diff=%02h", busy, done, diff);
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: busy=%b done=%b diff=%h bout=%b ovf=%b, need 0 0 00 0 0",
                  busy, done, diff, bout, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_no_resume: busy=%b done=%b, need 0 0", busy, done);
      end
      launch8(8'h09, 8'h04, 1'b0, k, bc);
      tests_run++;
      if (k !== 9 || diff !== 8'h05 || bout !== 1'b0 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL after_reset_op: k=%0d diff=%h bout=%b ovf=%b, need 9 05 0 0", k, diff, bout, ovf);
      end
   endtask

   task automatic test_width1;
      // index = {x, y, br}
      logic [7:0] exp_d;
      logic [7:0] exp_b;
      logic [7:0] exp_o;
      logic [2:0] idx;
      int k;
      bit seen;
      exp_d = 8'b1001_0110;
      exp_b = 8'b1000_1110;
      exp_o = 8'b0010_0100;
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         @(negedge clk);
         a1 = idx[2]; b1 = idx[1]; bin1 = idx[0]; start1 = 1'b1;
         @(posedge clk);
         #1 start1 = 1'b0;
         seen = 0; k = 0;
         for (int j = 1; j <= 10 && !seen; j++) begin
            @(negedge clk);
            if (done1) begin
               seen = 1;
               k = j;
            end
         end
         $display("[TB] w1 op %0d - %0d - %0d -> d=%0d bo=%0d ovf=%0d after %0d cycles",
                  idx[2], idx[1], idx[0], diff1, bout1, ovf1, k);
         tests_run++;
         if (k !== 2 || diff1 !== exp_d[i] || bout1 !== exp_b[i] || ovf1 !== exp_o[i]) begin
            tests_failed++;
            $display("FAIL w1_case%0d: k=%0d d=%b bo=%b ovf=%b, need 2 %b %b %b",
                     i, k, diff1, bout1, ovf1, exp_d[i], exp_b[i], exp_o[i]);
         end
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_basic();
      test_borrow();
      test_overflow();
      test_back_to_back();
      test_async_reset();
      test_width1();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
